// File: rtl/shift_add_multi_ctrl.sv
// Sequential unsigned shift-and-add multiplier: one partial product per clock.
// The result is the live {acc_hi, mplr} register pair, so it holds after DONE until the next start.
module shift_add_multi_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic [WIDTH-1:0]   out,
  output logic               ovf
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] mplr;
  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   sum;
  logic             accept;
  logic             last_step;

  assign accept    = (state == IDLE) && start;
  assign last_step = (state == CALC) && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CALC;
      CALC:    if (last_step) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      CALC:    busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // The sum keeps its carry bit; it shifts down into the top of acc_hi.
  always_comb begin
    addend = mplr[0] ? mcand : '0;
    sum    = {1'b0, acc_hi} + {1'b0, addend};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      acc_hi <= '0;
      mplr   <= '0;
      cnt    <= '0;
    end else if (accept) begin
      mcand  <= a;
      acc_hi <= '0;
      mplr   <= b;
      cnt    <= '0;
    end else if (state == CALC) begin
      acc_hi <= sum[WIDTH:1];
      mplr   <= WIDTH'({sum[0], mplr} >> 1);
      cnt    <= cnt + CW'(1);
    end
  end

  assign product = {acc_hi, mplr};
  assign out     = product[WIDTH-1:0];
  assign ovf     = |product[2*WIDTH-1:WIDTH];

`ifndef SYNTHESIS
  busy_done_exclusive: assert property (@(posedge clk) disable iff (!rst_n) !(busy && done));
  done_single_cycle: assert property (@(posedge clk) disable iff (!rst_n) done |=> !done);
`endif

endmodule

// File: tb/tb_shift_add_multi_ctrl.sv
// Self-checking bench for shift_add_multi_ctrl: directed vector table, hand-written
// corner sequences and randomized operands against a plain a*b reference.
module tb_shift_add_multi_ctrl;

  localparam int WIDTH = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [7:0]   a;
  logic [7:0]   b;
  logic         busy;
  logic         done;
  logic [15:0]  product;
  logic [7:0]   out;
  logic         ovf;

  int checks   = 0;
  int failures = 0;
  int overlap  = 0;

  int          obs_done_k;
  int          obs_done_cnt;
  int          obs_busy_cnt;
  logic [15:0] obs_product;
  logic [7:0]  obs_out;
  logic        obs_ovf;
  logic [15:0] obs_hold;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] product;
    logic [7:0]  out;
    logic        ovf;
  } vec_t;

  vec_t vecs[7];

  shift_add_multi_ctrl #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product),
    .out     (out),
    .ovf     (ovf)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (busy && done) overlap++;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
    end
  endtask

  // One transaction observed over 12 cycles; optionally injects an FF*FF start at cycle inject_k
  // and scrambles a/b while the multiply is running.
  task automatic applyStimulus(input logic [7:0] ta, input logic [7:0] tbv, input int inject_k, input bit scramble);
    obs_done_k   = -1;
    obs_done_cnt = 0;
    obs_busy_cnt = 0;
    obs_product  = 'x;
    obs_out      = 'x;
    obs_ovf      = 1'bx;
    obs_hold     = 'x;
    @(negedge clk);
    a     = ta;
    b     = tbv;
    start = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (busy) obs_busy_cnt++;
      if (done) begin
        obs_done_cnt++;
        if (obs_done_k < 0) begin
          obs_done_k  = k;
          obs_product = product;
          obs_out     = out;
          obs_ovf     = ovf;
        end
      end
      if (k == 12) obs_hold = product;
      start = (inject_k != 0) && (k == inject_k);
      if (start) begin
        a = 8'hFF;
        b = 8'hFF;
      end else if (scramble) begin
        a = 8'($urandom);
        b = 8'($urandom);
      end
    end
  endtask

  task automatic checkResult(input string name, input logic [15:0] exp_product, input logic [7:0] exp_out, input logic exp_ovf);
    checkOutput({name, "_done_cycle"}, obs_done_k, 32'd9);
    checkOutput({name, "_done_count"}, obs_done_cnt, 32'd1);
    checkOutput({name, "_busy_cycles"}, obs_busy_cnt, 32'd8);
    checkOutput({name, "_product"}, 32'(obs_product), 32'(exp_product));
    checkOutput({name, "_out"}, 32'(obs_out), 32'(exp_out));
    checkOutput({name, "_ovf"}, 32'(obs_ovf), 32'(exp_ovf));
    checkOutput({name, "_hold"}, 32'(obs_hold), 32'(exp_product));
  endtask

  initial begin
    logic [7:0]  ra;
    logic [7:0]  rb;
    logic [15:0] rp;
    int          seen;

    vecs[0] = '{8'h0C, 8'h0A, 16'h0078, 8'h78, 1'b0};
    vecs[1] = '{8'hFF, 8'hFF, 16'hFE01, 8'h01, 1'b1};
    vecs[2] = '{8'h00, 8'hB7, 16'h0000, 8'h00, 1'b0};
    vecs[3] = '{8'h81, 8'h01, 16'h0081, 8'h81, 1'b0};
    vecs[4] = '{8'h80, 8'h02, 16'h0100, 8'h00, 1'b1};
    vecs[5] = '{8'h0F, 8'h11, 16'h00FF, 8'hFF, 1'b0};
    vecs[6] = '{8'hAA, 8'h55, 16'h3872, 8'h72, 1'b1};

    rst_n = 1'b0;
    start = 1'b0;
    a     = 8'h00;
    b     = 8'h00;

    // Reset must clear outputs before the first clock edge.
    #3;
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_product", 32'(product), 32'd0);
    checkOutput("reset_out", 32'(out), 32'd0);
    checkOutput("reset_ovf", 32'(ovf), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("idle_busy", 32'(busy), 32'd0);
    checkOutput("idle_product", 32'(product), 32'd0);

    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, 0, 1'b0);
      checkResult($sformatf("vec%0d", i), vecs[i].product, vecs[i].out, vecs[i].ovf);
    end

    $display("[TB] start pulsed during CALC must be ignored");
    applyStimulus(8'h10, 8'h10, 3, 1'b0);
    checkResult("ignored_start", 16'h0100, 8'h00, 1'b1);

    $display("[TB] reset asserted mid-CALC");
    @(negedge clk);
    a     = 8'hFF;
    b     = 8'hFF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_done", 32'(done), 32'd0);
    checkOutput("abort_product", 32'(product), 32'd0);
    checkOutput("abort_out", 32'(out), 32'd0);
    checkOutput("abort_ovf", 32'(ovf), 32'd0);
    seen = 0;
    repeat (2) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    rst_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (done) seen++;
    end
    checkOutput("abort_no_done", seen, 32'd0);
    applyStimulus(8'h03, 8'h05, 0, 1'b0);
    checkResult("after_abort", 16'h000F, 8'h0F, 1'b0);

    $display("[TB] start held high: back-to-back multiplies");
    @(negedge clk);
    a     = 8'h02;
    b     = 8'h03;
    start = 1'b1;
    seen  = 0;
    for (int k = 1; k <= 42; k++) begin
      @(negedge clk);
      if (done) begin
        if (seen < 3) checkOutput($sformatf("held_pos%0d", seen), k, 32'(9 + 10 * seen));
        checkOutput("held_product", 32'(product), 32'h0006);
        seen++;
      end
      if (k == 30) start = 1'b0;
    end
    checkOutput("held_pulses", seen, 32'd3);

    $display("[TB] randomized operands, a/b scrambled during CALC");
    for (int i = 0; i < 20; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rp = 16'(ra) * 16'(rb);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      applyStimulus(ra, rb, 0, 1'b1);
      checkResult($sformatf("rand%0d", i), rp, rp[7:0], |rp[15:8]);
    end

    checkOutput("busy_done_overlap", overlap, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
